// File: rtl/sort_pkg.sv
// Shared types and constants for the in-place bubble sort engine.
package sort_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5,
    ERROR   = 3'd6
  } sort_state_e;

  localparam int unsigned RESP_OKAY = 32'd0;

endpackage

// File: rtl/sort_engine_if.sv
// Memory-side read (AR/R) and write (AW/W/B) channels of the sort engine.
interface sort_engine_if #(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 1
) ();

  logic                 ar_valid;
  logic                 ar_ready;
  logic [ADDR_WDTH-1:0] ar_address;
  logic                 r_valid;
  logic                 r_ready;
  logic [DATA_WDTH-1:0] r_data;
  logic [RESP_WDTH-1:0] r_resp;
  logic                 aw_valid;
  logic                 aw_ready;
  logic [ADDR_WDTH-1:0] aw_address;
  logic                 w_valid;
  logic                 w_ready;
  logic [DATA_WDTH-1:0] w_data;
  logic                 b_valid;
  logic [RESP_WDTH-1:0] b_resp;
  logic                 b_ready;

  modport master (
    output ar_valid, ar_address, r_ready, aw_valid, aw_address, w_valid, w_data, b_ready,
    input  ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
  );

  modport slave (
    input  ar_valid, ar_address, r_ready, aw_valid, aw_address, w_valid, w_data, b_ready,
    output ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
  );

endinterface

// File: rtl/sort_cmp.sv
// Element comparator: high when the running element a must sort after b.
module sort_cmp #(
  parameter int DATA_WDTH  = 32,
  parameter int SIGNED_CMP = 0
) (
  input  logic [DATA_WDTH-1:0] a,
  input  logic [DATA_WDTH-1:0] b,
  input  logic                 descending,
  output logic                 swap
);

  logic a_gt_b_s;
  logic a_lt_b_s;

  // Equal elements never swap, so ordering stays stable.
  always_comb begin
    if (SIGNED_CMP != 0) begin
      a_gt_b_s = $signed(a) > $signed(b);
      a_lt_b_s = $signed(a) < $signed(b);
    end else begin
      a_gt_b_s = a > b;
      a_lt_b_s = a < b;
    end
    swap = descending ? a_lt_b_s : a_gt_b_s;
  end

endmodule

// File: rtl/sort_engine.sv
// In-place bubble sort over a word-addressed memory reached through
// single-outstanding read and write channels; addresses wrap modulo 2^ADDR_WDTH.
module sort_engine
  import sort_pkg::*;
#(
  parameter int ADDR_WDTH  = 4,
  parameter int DATA_WDTH  = 32,
  parameter int RESP_WDTH  = 1,
  parameter int SIGNED_CMP = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_WDTH-1:0] cfg_base,
  input  logic [ADDR_WDTH:0]   cfg_len,
  input  logic                 cfg_descending,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  sort_engine_if.master        mem
);

  localparam logic [RESP_WDTH-1:0] OKAY_RESP = RESP_WDTH'(RESP_OKAY);

  sort_state_e          state_r, state_nx;
  logic [ADDR_WDTH-1:0] base_r, base_nx, last_r, last_nx, idx_r, idx_nx;
  logic [ADDR_WDTH-1:0] ar_addr_r, ar_addr_nx, aw_addr_r, aw_addr_nx;
  logic [DATA_WDTH-1:0] a_r, a_nx, w_data_r, w_data_nx;
  logic                 desc_r, desc_nx, swap_r, swap_nx, seed_r, seed_nx, final_r, final_nx;
  logic                 ar_valid_r, r_ready_r, aw_valid_r, w_valid_r, b_ready_r;
  logic                 aw_valid_nx, w_valid_nx;
  logic                 busy_r, done_r, error_r;
  logic                 cmp_swap_s, r_hs_s, b_hs_s, wr_sent_s;

  sort_cmp #(.DATA_WDTH(DATA_WDTH), .SIGNED_CMP(SIGNED_CMP)) u_cmp (
    .a          (a_r),
    .b          (mem.r_data),
    .descending (desc_r),
    .swap       (cmp_swap_s)
  );

  assign r_hs_s    = mem.r_valid & r_ready_r;
  assign b_hs_s    = mem.b_valid & b_ready_r;
  assign wr_sent_s = (~aw_valid_r | mem.aw_ready) & (~w_valid_r | mem.w_ready);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nx;
  end

  // Next state and next datapath values; one pass = seed read, j reads/writes, final write.
  always_comb begin
    state_nx   = state_r;
    base_nx    = base_r;
    last_nx    = last_r;
    idx_nx     = idx_r;
    a_nx       = a_r;
    desc_nx    = desc_r;
    swap_nx    = swap_r;
    seed_nx    = seed_r;
    final_nx   = final_r;
    ar_addr_nx = ar_addr_r;
    aw_addr_nx = aw_addr_r;
    w_data_nx  = w_data_r;
    case (state_r)
      IDLE, DONE, ERROR: begin
        if (start) begin
          base_nx    = cfg_base;
          desc_nx    = cfg_descending;
          last_nx    = ADDR_WDTH'(cfg_len - (ADDR_WDTH+1)'(1));
          idx_nx     = '0;
          swap_nx    = 1'b0;
          seed_nx    = 1'b1;
          final_nx   = 1'b0;
          ar_addr_nx = cfg_base;
          if (cfg_len <= (ADDR_WDTH+1)'(1)) state_nx = DONE;
          else                              state_nx = RD_ADDR;
        end else begin
          state_nx = state_r;
        end
      end
      RD_ADDR: begin
        if (mem.ar_ready) state_nx = RD_DATA;
        else              state_nx = RD_ADDR;
      end
      RD_DATA: begin
        if (!r_hs_s) begin
          state_nx = RD_DATA;
        end else if (mem.r_resp != OKAY_RESP) begin
          state_nx = ERROR;
        end else if (seed_r) begin
          a_nx       = mem.r_data;
          seed_nx    = 1'b0;
          idx_nx     = ADDR_WDTH'(1);
          ar_addr_nx = base_r + ADDR_WDTH'(1);
          state_nx   = RD_ADDR;
        end else begin
          aw_addr_nx = base_r + idx_r - ADDR_WDTH'(1);
          state_nx   = WR_REQ;
          if (cmp_swap_s) begin
            w_data_nx = mem.r_data;
            swap_nx   = 1'b1;
          end else begin
            w_data_nx = a_r;
            a_nx      = mem.r_data;
          end
        end
      end
      WR_REQ: begin
        if (wr_sent_s) state_nx = WR_RESP;
        else           state_nx = WR_REQ;
      end
      WR_RESP: begin
        if (!b_hs_s) begin
          state_nx = WR_RESP;
        end else if (mem.b_resp != OKAY_RESP) begin
          state_nx = ERROR;
        end else if (final_r) begin
          if (!swap_r || (last_r == ADDR_WDTH'(1))) begin
            state_nx = DONE;
          end else begin
            last_nx    = last_r - ADDR_WDTH'(1);
            idx_nx     = '0;
            swap_nx    = 1'b0;
            seed_nx    = 1'b1;
            final_nx   = 1'b0;
            ar_addr_nx = base_r;
            state_nx   = RD_ADDR;
          end
        end else if (idx_r == last_r) begin
          final_nx   = 1'b1;
          w_data_nx  = a_r;
          aw_addr_nx = base_r + last_r;
          state_nx   = WR_REQ;
        end else begin
          idx_nx     = idx_r + ADDR_WDTH'(1);
          ar_addr_nx = base_r + idx_r + ADDR_WDTH'(1);
          state_nx   = RD_ADDR;
        end
      end
      default: state_nx = IDLE;
    endcase

    // AW and W rise together on entry and each falls after its own handshake.
    if ((state_r != WR_REQ) && (state_nx == WR_REQ)) begin
      aw_valid_nx = 1'b1;
      w_valid_nx  = 1'b1;
    end else if (state_r == WR_REQ) begin
      aw_valid_nx = aw_valid_r & ~mem.aw_ready;
      w_valid_nx  = w_valid_r & ~mem.w_ready;
    end else begin
      aw_valid_nx = 1'b0;
      w_valid_nx  = 1'b0;
    end
  end

  // Datapath and registered channel/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_r <= '0;  last_r <= '0;  idx_r <= '0;  a_r <= '0;
      desc_r <= 1'b0;  swap_r <= 1'b0;  seed_r <= 1'b0;  final_r <= 1'b0;
      ar_addr_r <= '0;  aw_addr_r <= '0;  w_data_r <= '0;
      ar_valid_r <= 1'b0;  r_ready_r <= 1'b0;  aw_valid_r <= 1'b0;
      w_valid_r <= 1'b0;  b_ready_r <= 1'b0;
      busy_r <= 1'b0;  done_r <= 1'b0;  error_r <= 1'b0;
    end else begin
      base_r <= base_nx;  last_r <= last_nx;  idx_r <= idx_nx;  a_r <= a_nx;
      desc_r <= desc_nx;  swap_r <= swap_nx;  seed_r <= seed_nx;  final_r <= final_nx;
      ar_addr_r <= ar_addr_nx;  aw_addr_r <= aw_addr_nx;  w_data_r <= w_data_nx;
      ar_valid_r <= (state_nx == RD_ADDR);
      r_ready_r  <= (state_nx == RD_DATA);
      aw_valid_r <= aw_valid_nx;
      w_valid_r  <= w_valid_nx;
      b_ready_r  <= (state_nx == WR_RESP);
      busy_r     <= !((state_nx == IDLE) || (state_nx == DONE) || (state_nx == ERROR));
      done_r     <= (state_nx == DONE);
      error_r    <= (state_nx == ERROR);
    end
  end

  assign mem.ar_valid   = ar_valid_r;
  assign mem.ar_address = ar_addr_r;
  assign mem.r_ready    = r_ready_r;
  assign mem.aw_valid   = aw_valid_r;
  assign mem.aw_address = aw_addr_r;
  assign mem.w_valid    = w_valid_r;
  assign mem.w_data     = w_data_r;
  assign mem.b_ready    = b_ready_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign error          = error_r;

endmodule

// File: tb/tb_sort_engine.sv
// Self-checking bench: memory responder with optional random stalls, reference
// sort feeding an expected-value queue, channel stability and address-order checks.
module tb_sort_engine;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int RW = 1;
  localparam int LIMIT = 20000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] cfg_base = '0;
  logic [AW:0]   cfg_len = '0;
  logic          cfg_descending = 1'b0;
  logic          busy, done, error;

  sort_engine_if #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW)) mem_if ();

  sort_engine #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW), .SIGNED_CMP(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .cfg_descending(cfg_descending), .busy(busy), .done(done), .error(error), .mem(mem_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [DW-1:0] model_mem [16];
  logic [DW-1:0] load_vals [16];
  logic [DW-1:0] ref_vals  [16];
  logic [DW-1:0] exp_q [$];
  int            rd_trace [$];
  int            wr_trace [$];
  int            rd_cnt = 0;
  int            wr_cnt = 0;
  bit            stall_en = 1'b0;
  bit            inject_berr = 1'b0;

  // Responder state
  bit            rd_busy = 1'b0, aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0;
  int            r_dly = 0, b_dly = 0;
  logic [AW-1:0] rd_addr, wa, p_ar_addr, p_aw_addr, hold_ar_addr, hold_aw_addr;
  logic [DW-1:0] wd, p_w_data, hold_w_data;
  bit            p_ar = 1'b0, p_r = 1'b0, p_aw = 1'b0, p_w = 1'b0, p_b = 1'b0;
  bit            ar_hold = 1'b0, aw_hold = 1'b0, w_hold = 1'b0;

  function automatic bit rnd_ready();
    return stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
  endfunction

  initial begin : responder
    mem_if.ar_ready = 1'b0; mem_if.r_valid = 1'b0; mem_if.r_data = '0; mem_if.r_resp = '0;
    mem_if.aw_ready = 1'b0; mem_if.w_ready = 1'b0; mem_if.b_valid = 1'b0; mem_if.b_resp = '0;
    forever begin
      @(negedge clk);
      if (ar_hold) begin
        check_val("ar_valid_stable", mem_if.ar_valid, 1);
        check_val("ar_address_stable", mem_if.ar_address, hold_ar_addr);
      end
      if (aw_hold) begin
        check_val("aw_valid_stable", mem_if.aw_valid, 1);
        check_val("aw_address_stable", mem_if.aw_address, hold_aw_addr);
      end
      if (w_hold) begin
        check_val("w_valid_stable", mem_if.w_valid, 1);
        check_val("w_data_stable", mem_if.w_data, hold_w_data);
      end
      if (p_ar) begin
        rd_busy = 1'b1; rd_addr = p_ar_addr;
        r_dly = stall_en ? $urandom_range(0, 3) : 0;
        rd_trace.push_back(int'(p_ar_addr)); rd_cnt++;
      end
      if (p_r) mem_if.r_valid = 1'b0;
      if (p_aw) begin aw_got = 1'b1; wa = p_aw_addr; end
      if (p_w)  begin w_got = 1'b1;  wd = p_w_data;  end
      if (p_b)  begin mem_if.b_valid = 1'b0; b_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0; end
      if (rd_busy) begin
        if (r_dly == 0) begin
          mem_if.r_valid = 1'b1; mem_if.r_data = model_mem[rd_addr]; mem_if.r_resp = '0;
          rd_busy = 1'b0;
        end else r_dly--;
      end
      if (aw_got && w_got && !b_pend) begin
        model_mem[wa] = wd; wr_trace.push_back(int'(wa)); wr_cnt++;
        b_pend = 1'b1; b_dly = stall_en ? $urandom_range(0, 3) : 0;
      end
      if (b_pend && !mem_if.b_valid) begin
        if (b_dly == 0) begin
          mem_if.b_valid = 1'b1; mem_if.b_resp = RW'(inject_berr); inject_berr = 1'b0;
        end else b_dly--;
      end
      mem_if.ar_ready = (!rd_busy && !mem_if.r_valid) ? rnd_ready() : 1'b0;
      mem_if.aw_ready = !aw_got && rnd_ready();
      mem_if.w_ready  = !w_got && rnd_ready();
      // Handshakes that the coming rising edge will complete
      p_ar = mem_if.ar_valid & mem_if.ar_ready;  p_ar_addr = mem_if.ar_address;
      p_aw = mem_if.aw_valid & mem_if.aw_ready;  p_aw_addr = mem_if.aw_address;
      p_w  = mem_if.w_valid & mem_if.w_ready;    p_w_data  = mem_if.w_data;
      p_r  = mem_if.r_valid & mem_if.r_ready;
      p_b  = mem_if.b_valid & mem_if.b_ready;
      ar_hold = mem_if.ar_valid & ~mem_if.ar_ready;  hold_ar_addr = mem_if.ar_address;
      aw_hold = mem_if.aw_valid & ~mem_if.aw_ready;  hold_aw_addr = mem_if.aw_address;
      w_hold  = mem_if.w_valid & ~mem_if.w_ready;    hold_w_data  = mem_if.w_data;
    end
  end

  function automatic bit sorts_before(input logic [DW-1:0] x, input logic [DW-1:0] y, input bit desc);
    return desc ? ($signed(x) > $signed(y)) : ($signed(x) < $signed(y));
  endfunction

  task automatic run_sort(input int base, input int len, input bit desc, input bit expect_err);
    int cyc;
    logic [DW-1:0] t;
    for (int i = 0; i < len; i++) begin
      model_mem[(base + i) % 16] = load_vals[i];
      ref_vals[i] = load_vals[i];
    end
    for (int i = 1; i < len; i++) begin
      for (int k = i; k > 0 && sorts_before(ref_vals[k], ref_vals[k-1], desc); k--) begin
        t = ref_vals[k]; ref_vals[k] = ref_vals[k-1]; ref_vals[k-1] = t;
      end
    end
    if (!expect_err) for (int i = 0; i < len; i++) exp_q.push_back(ref_vals[i]);
    rd_cnt = 0; wr_cnt = 0; rd_trace.delete(); wr_trace.delete();
    @(negedge clk);
    cfg_base = AW'(base); cfg_len = (AW+1)'(len); cfg_descending = desc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(done || error) && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    check_val("completion_timeout", cyc < LIMIT, 1);
    check_val("done", done, !expect_err);
    check_val("error", error, expect_err);
    check_val("busy_idle", busy, 0);
    if (!expect_err) begin
      for (int i = 0; i < len; i++) check_val("sorted_word", model_mem[(base + i) % 16], exp_q.pop_front());
    end
  endtask

  initial begin : main
    int others;
    repeat (3) @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_error", error, 0);
    check_val("rst_ar_valid", mem_if.ar_valid, 0);
    check_val("rst_aw_w_valid", {mem_if.aw_valid, mem_if.w_valid}, 0);
    check_val("rst_ready", {mem_if.r_ready, mem_if.b_ready}, 0);
    check_val("rst_addr_data", {mem_if.ar_address, mem_if.aw_address, mem_if.w_data}, 0);
    rst_n = 1'b1;

    load_vals[0] = 32'd3; load_vals[1] = 32'd1; load_vals[2] = 32'd4; load_vals[3] = 32'd2;
    run_sort(0, 4, 1'b0, 1'b0);
    check_val("asc_word0_const", model_mem[0], 32'd1);
    check_val("asc_word3_const", model_mem[3], 32'd4);

    load_vals[0] = 32'hFFFF_FFFF; load_vals[1] = 32'd5; load_vals[2] = 32'd0; load_vals[3] = 32'hFFFF_FFF9;
    run_sort(0, 4, 1'b1, 1'b0);
    check_val("desc_word0_const", model_mem[0], 32'd5);
    check_val("desc_word2_const", model_mem[2], 32'hFFFF_FFFF);

    load_vals[0] = 32'd1; load_vals[1] = 32'd2; load_vals[2] = 32'd3; load_vals[3] = 32'd4;
    run_sort(0, 4, 1'b0, 1'b0);
    check_val("sorted_read_count", rd_cnt, 4);
    check_val("sorted_write_count", wr_cnt, 4);

    load_vals[0] = 32'd9; load_vals[1] = 32'd8; load_vals[2] = 32'd7; load_vals[3] = 32'd6;
    run_sort(14, 4, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_val("wrap_read_addr", (i < rd_trace.size()) ? rd_trace[i] : -1, (14 + i) % 16);
      check_val("wrap_write_addr", (i < wr_trace.size()) ? wr_trace[i] : -1, (14 + i) % 16);
    end

    run_sort(5, 0, 1'b0, 1'b0);
    check_val("len0_traffic", rd_cnt + wr_cnt, 0);
    load_vals[0] = 32'd77;
    run_sort(5, 1, 1'b0, 1'b0);
    check_val("len1_traffic", rd_cnt + wr_cnt, 0);

    inject_berr = 1'b1;
    load_vals[0] = 32'd4; load_vals[1] = 32'd3; load_vals[2] = 32'd2; load_vals[3] = 32'd1;
    run_sort(0, 4, 1'b0, 1'b1);
    others = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_if.ar_valid || mem_if.aw_valid || mem_if.w_valid) others++;
    end
    check_val("err_no_traffic", others, 0);
    check_val("err_write_count", wr_cnt, 1);
    check_val("err_still_flagged", {error, done}, 2'b10);

    stall_en = 1'b1;
    for (int it = 0; it < 5; it++) begin
      int len;
      len = (it == 0) ? 16 : $urandom_range(2, 16);
      for (int i = 0; i < len; i++) load_vals[i] = (it % 2 == 0) ? $urandom() : DW'($urandom_range(0, 5));
      run_sort($urandom_range(0, 15), len, ($urandom_range(0, 1) == 1), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
